// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry and scheduler state encoding.
package fb_pkg;
  localparam int FRAMEBUFFER_SIZE = 307200;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 4;
  typedef enum logic [1:0] {CLEAR, DRAW, WAIT_SWAP} fb_sched_state_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;
endpackage

// File: rtl/rr_dual_arbiter.sv
// rr_dual_arbiter: picks up to two valid requesters in round-robin order, refusing a second grant that targets the same pixel.
module rr_dual_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 19,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]        valid,
  input  logic [PW-1:0]             ptr,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        grant1,
  output logic [NUM_REQ-1:0]        grant2,
  output logic [PW-1:0]             idx1,
  output logic [PW-1:0]             idx2,
  output logic [PW-1:0]             next_ptr
);
  logic found1, found2;
  logic [PW-1:0] j;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    return (i == PW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    grant1 = '0;
    grant2 = '0;
    idx1 = '0;
    idx2 = '0;
    found1 = 1'b0;
    found2 = 1'b0;
    j = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = PW'((int'(ptr) + k) % NUM_REQ);
      // only the very next valid requester is a port-2 candidate
      if (valid[j] && found1 && !found2) begin
        found2 = 1'b1;
        if (addr[j*ADDR_W +: ADDR_W] != addr[idx1*ADDR_W +: ADDR_W]) begin
          grant2[j] = 1'b1;
          idx2 = j;
        end
      end
      if (valid[j] && !found1) begin
        found1 = 1'b1;
        grant1[j] = 1'b1;
        idx1 = j;
      end
    end
    next_ptr = |grant2 ? wrap_inc(idx2) : |grant1 ? wrap_inc(idx1) : ptr;
  end
endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: clears the back buffer after each swap, then shares both framebuffer write ports among draw requesters.
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DATA_W = fb_pkg::DATA_W,
  parameter int FB_SIZE = fb_pkg::FRAMEBUFFER_SIZE,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      vsync,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      frame_done,
  output logic                      frame_start,
  output logic                      clearing,
  output logic                      frame_overrun,
  output logic [ADDR_W-1:0]         addr_wr1,
  output logic [ADDR_W-1:0]         addr_wr2,
  output logic [DATA_W-1:0]         data_wr1,
  output logic [DATA_W-1:0]         data_wr2,
  output logic                      wr1_en,
  output logic                      wr2_en
);
  fb_sched_state_t state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d, a1_d, a2_d;
  logic [DATA_W-1:0] d1_d, d2_d;
  logic [PW-1:0] ptr, next_ptr, idx1, idx2;
  logic [NUM_REQ-1:0] grant1, grant2;
  logic vsync_q, vsync_fall, clear_last, wr1_d, wr2_d, draw;

  rr_dual_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) u_arb (
    .valid(req_valid),
    .ptr(ptr),
    .addr(req_addr),
    .grant1(grant1),
    .grant2(grant2),
    .idx1(idx1),
    .idx2(idx2),
    .next_ptr(next_ptr)
  );

  assign draw = state == DRAW;
  assign vsync_fall = vsync_q & ~vsync;
  assign clear_last = cnt == ADDR_W'(FB_SIZE - 2);
  assign clearing = state == CLEAR;
  assign req_ready = draw ? grant1 | grant2 : '0;

  always_comb begin
    state_d = state;
    cnt_d = cnt;
    wr1_d = 1'b0;
    wr2_d = 1'b0;
    a1_d = cnt;
    a2_d = cnt + ADDR_W'(1);
    d1_d = CLEAR_COLOR;
    d2_d = CLEAR_COLOR;
    case (state)
      CLEAR: begin
        wr1_d = 1'b1;
        wr2_d = 1'b1;
        cnt_d = clear_last ? '0 : cnt + ADDR_W'(2);
        state_d = clear_last ? DRAW : CLEAR;
      end
      DRAW: begin
        wr1_d = |grant1;
        wr2_d = |grant2;
        a1_d = req_addr[idx1*ADDR_W +: ADDR_W];
        a2_d = req_addr[idx2*ADDR_W +: ADDR_W];
        d1_d = req_data[idx1*DATA_W +: DATA_W];
        d2_d = req_data[idx2*DATA_W +: DATA_W];
        state_d = frame_done ? WAIT_SWAP : DRAW;
      end
      WAIT_SWAP: begin
        cnt_d = '0;
        state_d = vsync_fall ? CLEAR : WAIT_SWAP;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      cnt <= '0;
      ptr <= '0;
      vsync_q <= 1'b1;
      frame_start <= 1'b0;
      frame_overrun <= 1'b0;
      wr1_en <= 1'b0;
      wr2_en <= 1'b0;
      addr_wr1 <= '0;
      addr_wr2 <= '0;
      data_wr1 <= '0;
      data_wr2 <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      vsync_q <= vsync;
      frame_start <= clearing && clear_last;
      frame_overrun <= vsync_fall && state != WAIT_SWAP;
      wr1_en <= wr1_d;
      wr2_en <= wr2_d;
      if (wr1_d) begin
        addr_wr1 <= a1_d;
        data_wr1 <= d1_d;
      end
      if (wr2_d) begin
        addr_wr2 <= a2_d;
        data_wr2 <= d2_d;
      end
      if (draw) ptr <= next_ptr;
    end
  end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: scenario tasks plus randomized draw traffic against a rotation-order reference model.
module tb_fb_write_scheduler;
  localparam int N = 4;
  localparam int AW = 19;
  localparam int DW = 4;

  logic clock = 1'b0;
  logic reset, vsync, frame_done;
  logic [N-1:0] req_valid, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic frame_start, clearing, frame_overrun, wr1_en, wr2_en;
  logic [AW-1:0] addr_wr1, addr_wr2;
  logic [DW-1:0] data_wr1, data_wr2;

  int checks = 0;
  int failures = 0;
  int m_ptr;
  logic [AW-1:0] m_a1, m_a2;
  logic [DW-1:0] m_d1, m_d2;

  always #5 clock = ~clock;

  fb_write_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .FB_SIZE(16), .CLEAR_COLOR(4'h0)) dut (
    .clock(clock), .reset(reset), .vsync(vsync), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .frame_done(frame_done), .frame_start(frame_start),
    .clearing(clearing), .frame_overrun(frame_overrun), .addr_wr1(addr_wr1), .addr_wr2(addr_wr2),
    .data_wr1(data_wr1), .data_wr2(data_wr2), .wr1_en(wr1_en), .wr2_en(wr2_en)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Lists valid requesters in rotation order from the pointer; the first two become the grants.
  task automatic model_step(output logic [N-1:0] rdy, output logic e1, output logic e2);
    int q[$];
    for (int k = 0; k < N; k++) if (req_valid[(m_ptr + k) % N]) q.push_back((m_ptr + k) % N);
    rdy = '0;
    e1 = 1'b0;
    e2 = 1'b0;
    if (q.size() > 0) begin
      e1 = 1'b1;
      rdy[q[0]] = 1'b1;
      m_a1 = req_addr[q[0]*AW +: AW];
      m_d1 = req_data[q[0]*DW +: DW];
      m_ptr = (q[0] + 1) % N;
    end
    if (q.size() > 1 && req_addr[q[1]*AW +: AW] != req_addr[q[0]*AW +: AW]) begin
      e2 = 1'b1;
      rdy[q[1]] = 1'b1;
      m_a2 = req_addr[q[1]*AW +: AW];
      m_d2 = req_data[q[1]*DW +: DW];
      m_ptr = (q[1] + 1) % N;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    vsync = 1'b1;
    frame_done = 1'b0;
    req_valid = '1;
    req_addr = '0;
    req_data = '0;
    tick();
    tick();
    checks++; if ({wr1_en, wr2_en} !== 2'b00) begin failures++; $display("FAIL reset_en: got %b want 00", {wr1_en, wr2_en}); end
    checks++; if ({addr_wr1, addr_wr2, data_wr1, data_wr2} !== '0) begin failures++; $display("FAIL reset_bus: got %h want 0", {addr_wr1, addr_wr2, data_wr1, data_wr2}); end
    checks++; if ({frame_start, frame_overrun, clearing} !== 3'b001) begin failures++; $display("FAIL reset_flags: got %b want 001", {frame_start, frame_overrun, clearing}); end
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready: got %b want 0", req_ready); end
  endtask

  task automatic test_clear();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (clearing !== 1'b1 || req_ready !== '0) begin failures++; $display("FAIL clear_state[%0d]: got clearing=%b ready=%b want 1/0", i, clearing, req_ready); end
      tick();
      checks++; if ({wr1_en, wr2_en} !== 2'b11 || addr_wr1 !== AW'(2*i) || addr_wr2 !== AW'(2*i+1)) begin
        failures++; $display("FAIL clear_write[%0d]: got en=%b a=%0d/%0d want 11 %0d/%0d", i, {wr1_en, wr2_en}, addr_wr1, addr_wr2, 2*i, 2*i+1);
      end
      checks++; if ({data_wr1, data_wr2} !== 8'h00 || frame_start !== (i == 7)) begin
        failures++; $display("FAIL clear_data[%0d]: got d=%h fs=%b want 00 %b", i, {data_wr1, data_wr2}, frame_start, i == 7);
      end
    end
    req_valid = '0;
    checks++; if (clearing !== 1'b0) begin failures++; $display("FAIL clear_done: got clearing=%b want 0", clearing); end
    m_ptr = 0; m_a1 = 14; m_a2 = 15; m_d1 = 0; m_d2 = 0;
  endtask

  task automatic test_draw_all();
    logic [N-1:0] r;
    logic e1, e2;
    tick();
    checks++; if ({frame_start, wr1_en, wr2_en} !== 3'b000 || addr_wr1 !== 19'd14) begin
      failures++; $display("FAIL idle_hold: got fs/en=%b a1=%0d want 000 14", {frame_start, wr1_en, wr2_en}, addr_wr1);
    end
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'(10 + i);
      req_data[i*DW +: DW] = DW'(i + 1);
    end
    for (int c = 0; c < 4; c++) begin
      #1;
      model_step(r, e1, e2);
      checks++; if (req_ready !== r || r !== ((c % 2) ? 4'b1100 : 4'b0011)) begin failures++; $display("FAIL all_ready[%0d]: got %b want %b", c, req_ready, r); end
      tick();
      checks++; if ({wr1_en, wr2_en} !== {e1, e2} || addr_wr1 !== m_a1 || addr_wr2 !== m_a2 || data_wr1 !== m_d1 || data_wr2 !== m_d2) begin
        failures++; $display("FAIL all_write[%0d]: got en=%b a=%0d/%0d d=%h/%h want %b %0d/%0d %h/%h", c, {wr1_en, wr2_en}, addr_wr1, addr_wr2, data_wr1, data_wr2, {e1, e2}, m_a1, m_a2, m_d1, m_d2);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_conflict();
    logic [N-1:0] r;
    logic e1, e2;
    req_valid = 4'b0001;
    req_addr[0 +: AW] = 19'd20;
    req_data[0 +: DW] = 4'h7;
    #1;
    model_step(r, e1, e2);
    tick();
    req_valid = 4'b0110;
    req_addr[1*AW +: AW] = 19'd5;
    req_data[1*DW +: DW] = 4'h3;
    req_addr[2*AW +: AW] = 19'd5;
    req_data[2*DW +: DW] = 4'h9;
    #1;
    model_step(r, e1, e2);
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL conflict_ready1: got %b want 0010", req_ready); end
    tick();
    checks++; if ({wr1_en, wr2_en} !== 2'b10 || addr_wr1 !== 19'd5 || data_wr1 !== 4'h3) begin
      failures++; $display("FAIL conflict_write1: got en=%b a=%0d d=%h want 10 5 3", {wr1_en, wr2_en}, addr_wr1, data_wr1);
    end
    req_valid = 4'b0100;
    #1;
    model_step(r, e1, e2);
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL conflict_ready2: got %b want 0100", req_ready); end
    tick();
    checks++; if ({wr1_en, wr2_en} !== 2'b10 || addr_wr1 !== 19'd5 || data_wr1 !== 4'h9) begin
      failures++; $display("FAIL conflict_write2: got en=%b a=%0d d=%h want 10 5 9", {wr1_en, wr2_en}, addr_wr1, data_wr1);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic e1, e2;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          req_valid[i] = 1'b1;
          req_addr[i*AW +: AW] = AW'($urandom_range(7, 0));
          req_data[i*DW +: DW] = DW'($urandom);
        end
      end
      #1;
      model_step(r, e1, e2);
      checks++; if (req_ready !== r) begin failures++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, r); end
      tick();
      checks++; if ({wr1_en, wr2_en} !== {e1, e2} || addr_wr1 !== m_a1 || addr_wr2 !== m_a2 || data_wr1 !== m_d1 || data_wr2 !== m_d2) begin
        failures++; $display("FAIL rand_write[%0d]: got en=%b a=%0d/%0d d=%h/%h want %b %0d/%0d %h/%h", c, {wr1_en, wr2_en}, addr_wr1, addr_wr2, data_wr1, data_wr2, {e1, e2}, m_a1, m_a2, m_d1, m_d2);
      end
      req_valid = req_valid & ~r;
    end
    req_valid = '0;
  endtask

  task automatic test_overrun();
    logic [N-1:0] r;
    logic e1, e2;
    req_valid = 4'b1000;
    req_addr[3*AW +: AW] = 19'd9;
    req_data[3*DW +: DW] = 4'h2;
    vsync = 1'b0;
    #1;
    model_step(r, e1, e2);
    tick();
    checks++; if (frame_overrun !== 1'b1) begin failures++; $display("FAIL overrun_pulse: got %b want 1", frame_overrun); end
    checks++; if (wr1_en !== 1'b1 || addr_wr1 !== 19'd9 || data_wr1 !== 4'h2) begin
      failures++; $display("FAIL overrun_grant: got en=%b a=%0d d=%h want 1 9 2", wr1_en, addr_wr1, data_wr1);
    end
    req_valid = 4'b0001;
    req_addr[0 +: AW] = 19'd1;
    tick();
    checks++; if (frame_overrun !== 1'b0 || clearing !== 1'b0) begin failures++; $display("FAIL overrun_once: got ovr=%b clr=%b want 0 0", frame_overrun, clearing); end
    vsync = 1'b1;
    model_step(r, e1, e2);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL overrun_still_draw: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_frame_done();
    logic [N-1:0] r;
    logic e1, e2;
    req_valid = 4'b0001;
    req_addr[0 +: AW] = 19'd3;
    req_data[0 +: DW] = 4'h4;
    frame_done = 1'b1;
    #1;
    model_step(r, e1, e2);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL done_ready: got %b want 0001", req_ready); end
    tick();
    frame_done = 1'b0;
    req_valid = 4'b0010;
    req_addr[1*AW +: AW] = 19'd6;
    #1;
    checks++; if (wr1_en !== 1'b1 || addr_wr1 !== 19'd3 || data_wr1 !== 4'h4) begin
      failures++; $display("FAIL done_grant: got en=%b a=%0d d=%h want 1 3 4", wr1_en, addr_wr1, data_wr1);
    end
    for (int c = 0; c < 3; c++) begin
      checks++; if (req_ready !== '0 || clearing !== 1'b0) begin failures++; $display("FAIL wait_ready[%0d]: got rdy=%b clr=%b want 0 0", c, req_ready, clearing); end
      if (c < 2) tick();
    end
    tick();
    checks++; if ({wr1_en, wr2_en} !== 2'b00) begin failures++; $display("FAIL wait_en: got %b want 00", {wr1_en, wr2_en}); end
    vsync = 1'b0;
    tick();
    checks++; if (clearing !== 1'b1 || frame_overrun !== 1'b0) begin failures++; $display("FAIL swap: got clr=%b ovr=%b want 1 0", clearing, frame_overrun); end
    tick();
    vsync = 1'b1;
    checks++; if ({wr1_en, wr2_en} !== 2'b11 || addr_wr1 !== 19'd0 || addr_wr2 !== 19'd1 || frame_overrun !== 1'b0) begin
      failures++; $display("FAIL reclear: got en=%b a=%0d/%0d ovr=%b want 11 0/1 0", {wr1_en, wr2_en}, addr_wr1, addr_wr2, frame_overrun);
    end
    req_valid = '0;
    repeat (7) tick();
    checks++; if (frame_start !== 1'b1 || addr_wr2 !== 19'd15) begin failures++; $display("FAIL reclear_end: got fs=%b a2=%0d want 1 15", frame_start, addr_wr2); end
  endtask

  task automatic test_reset_mid_clear();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    repeat (4) tick();
    checks++; if (addr_wr1 !== 19'd6 || wr1_en !== 1'b1) begin failures++; $display("FAIL mid_clear: got a1=%0d en=%b want 6 1", addr_wr1, wr1_en); end
    reset = 1'b0;
    #1;
    checks++; if ({wr1_en, wr2_en} !== 2'b00 || clearing !== 1'b1 || addr_wr1 !== 19'd0) begin
      failures++; $display("FAIL abort: got en=%b clr=%b a1=%0d want 00 1 0", {wr1_en, wr2_en}, clearing, addr_wr1);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++; if ({wr1_en, wr2_en} !== 2'b11 || addr_wr1 !== 19'd0 || addr_wr2 !== 19'd1) begin
      failures++; $display("FAIL restart: got en=%b a=%0d/%0d want 11 0/1", {wr1_en, wr2_en}, addr_wr1, addr_wr2);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_draw_all();
    test_conflict();
    test_random();
    test_overrun();
    test_frame_done();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
